nes_button_events: RTL and testbench

- Downstream consumer of the NES controller driver's parallel 8-bit button vector.
- Per button, debounces across consecutive controller polls and emits one-cycle press and release event pulses.
- Generates typematic auto-repeat pulses for held buttons selected by a mask (default: D-pad).
- Game logic reads events from this block and never reads the raw vector.

---
 rtl/nes_pkg.sv | 28 ++
 rtl/nes_btn_channel.sv | 129 ++++++++++++
 rtl/nes_button_events.sv | 48 ++++
 tb/tb_nes_button_events.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared constants and types for the NES button event block.
package nes_pkg;

    localparam int N_BTN = 8;

    // Bit positions within the polled controller vector
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Typematic repeat states for a single button
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Larger of two integers, used to size the repeat counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_btn_channel.sv
// One button: poll-based debounce, press/release detection and
// typematic auto-repeat. All pulses are registered and last one cycle.
module nes_btn_channel
    import nes_pkg::*;
#(
    parameter int STABLE_POLLS = 2,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_valid,
    input  logic cand,
    output logic state,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);

    localparam int DW = $clog2(STABLE_POLLS + 1);
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

    // Counter values on which the next qualifying poll completes the interval
    localparam logic [DW-1:0] DEB_LAST   = DW'(STABLE_POLLS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic            state_reg,     state_next;
    logic [DW-1:0]   deb_cnt_reg,   deb_cnt_next;
    rep_state_t      rep_state_reg, rep_state_next;
    logic [RW-1:0]   rep_cnt_reg,   rep_cnt_next;
    logic            pressed_reg,   pressed_next;
    logic            released_reg,  released_next;
    logic            repeat_reg,    repeat_next;

    // State and pulse registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= 1'b0;
            deb_cnt_reg   <= '0;
            rep_state_reg <= IDLE;
            rep_cnt_reg   <= '0;
            pressed_reg   <= 1'b0;
            released_reg  <= 1'b0;
            repeat_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            deb_cnt_reg   <= deb_cnt_next;
            rep_state_reg <= rep_state_next;
            rep_cnt_reg   <= rep_cnt_next;
            pressed_reg   <= pressed_next;
            released_reg  <= released_next;
            repeat_reg    <= repeat_next;
        end
    end

    // Next-state logic: everything holds and pulses drop between polls
    always_comb begin
        state_next     = state_reg;
        deb_cnt_next   = deb_cnt_reg;
        rep_state_next = rep_state_reg;
        rep_cnt_next   = rep_cnt_reg;
        pressed_next   = 1'b0;
        released_next  = 1'b0;
        repeat_next    = 1'b0;

        if (sample_valid) begin
            // Debounce: a disagreeing level must persist for STABLE_POLLS polls
            if (cand == state_reg) begin
                deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                state_next   = cand;
                deb_cnt_next = '0;
                if (cand) begin
                    pressed_next = 1'b1;
                end else begin
                    released_next = 1'b1;
                end
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end

            // Repeat: release always wins, so no pulse on the release poll
            if (REPEAT_EN) begin
                if (released_next) begin
                    rep_state_next = IDLE;
                    rep_cnt_next   = '0;
                end else begin
                    case (rep_state_reg)
                        IDLE: begin
                            if (pressed_next) begin
                                rep_state_next = DELAY;
                                rep_cnt_next   = '0;
                            end
                        end
                        DELAY: begin
                            if (rep_cnt_reg == DELAY_LAST) begin
                                repeat_next    = 1'b1;
                                rep_state_next = REPEAT;
                                rep_cnt_next   = '0;
                            end else begin
                                rep_cnt_next = rep_cnt_reg + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rep_cnt_reg == RATE_LAST) begin
                                repeat_next  = 1'b1;
                                rep_cnt_next = '0;
                            end else begin
                                rep_cnt_next = rep_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            rep_state_next = IDLE;
                            rep_cnt_next   = '0;
                        end
                    endcase
                end
            end
        end
    end

    assign state        = state_reg;
    assign pressed      = pressed_reg;
    assign released     = released_reg;
    assign repeat_pulse = repeat_reg;

endmodule

// File: rtl/nes_button_events.sv
// Turns the polled NES controller vector into debounced levels and
// one-cycle press, release and auto-repeat events for game logic.
module nes_button_events
    import nes_pkg::*;
#(
    parameter bit               ACTIVE_LOW   = 1'b1,
    parameter int               STABLE_POLLS = 2,
    parameter int               REPEAT_DELAY = 30,
    parameter int               REPEAT_RATE  = 6,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 8'hF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_event
);

    // Normalised poll: 1 = pressed regardless of wire polarity
    logic [N_BTN-1:0] cand;
    assign cand = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        nes_btn_channel #(
            .STABLE_POLLS (STABLE_POLLS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[gi])
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .sample_valid (sample_valid),
            .cand         (cand[gi]),
            .state        (btn_state[gi]),
            .pressed      (pressed[gi]),
            .released     (released[gi]),
            .repeat_pulse (repeat_pulse[gi])
        );
    end

    // Pulses are already registered, so this OR lines up with them
    assign any_event = |{pressed, released, repeat_pulse};

endmodule

// File: tb/tb_nes_button_events.sv
// Self-checking bench for nes_button_events: vector table, hand-written
// corner sequences and a random walk against a behavioural model.
module tb_nes_button_events;
    import nes_pkg::*;

    localparam int          SP   = 2;
    localparam int          RD   = 4;
    localparam int          RR   = 2;
    localparam logic [7:0]  MASK = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [7:0] btn_raw;
    logic [7:0] btn_state, pressed, released, repeat_pulse;
    logic       any_event;

    always #5 clk = ~clk;

    nes_button_events #(
        .ACTIVE_LOW   (1'b1),
        .STABLE_POLLS (SP),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .btn_raw      (btn_raw),
        .btn_state    (btn_state),
        .pressed      (pressed),
        .released     (released),
        .repeat_pulse (repeat_pulse),
        .any_event    (any_event)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Per button: length of the current run of polls disagreeing with the
    // debounced level, and number of polls held since the press poll.
    int         run_len [8];
    int         held    [8];
    logic [7:0] m_state, m_p, m_r, m_rp;
    logic [7:0] mask_v;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            run_len[i] = 0;
            held[i]    = 0;
        end
        m_state = '0; m_p = '0; m_r = '0; m_rp = '0;
    endtask

    task automatic model_poll(input logic [7:0] raw);
        logic [7:0] c;
        c = ~raw;
        m_p = '0; m_r = '0; m_rp = '0;
        for (int i = 0; i < 8; i++) begin
            if (c[i] == m_state[i]) begin
                run_len[i] = 0;
            end else begin
                run_len[i]++;
                if (run_len[i] == SP) begin
                    run_len[i] = 0;
                    m_state[i] = c[i];
                    if (c[i]) begin
                        m_p[i]  = 1'b1;
                        held[i] = 0;
                    end else begin
                        m_r[i] = 1'b1;
                    end
                end
            end
            if (m_state[i] && !m_p[i]) begin
                held[i]++;
                if (mask_v[i] && (held[i] == RD ||
                    (held[i] > RD && ((held[i] - RD) % RR) == 0)))
                    m_rp[i] = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk8({tag, ".btn_state"}, btn_state, m_state);
        chk8({tag, ".pressed"}, pressed, m_p);
        chk8({tag, ".released"}, released, m_r);
        chk8({tag, ".repeat"}, repeat_pulse, m_rp);
        chk8({tag, ".any_event"}, {7'b0, any_event}, {7'b0, |(m_p | m_r | m_rp)});
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic poll(input logic [7:0] raw);
        btn_raw      = raw;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        model_poll(raw);
    endtask

    task automatic gap(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            btn_raw = 8'($urandom);
            @(negedge clk);
            m_p = '0; m_r = '0; m_rp = '0;
            check_model(tag);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        btn_raw      = 8'hFF;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] raw;
        logic [7:0] st;
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] rp;
    } vec_t;

    vec_t tbl [30];

    initial begin
        int         cnt_p0, cnt_rp0;
        logic [7:0] raw;

        mask_v = MASK;
        tbl[0]  = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'hFE, 8'h01, 8'h01, 8'h00, 8'h00};
        tbl[2]  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h00};
        tbl[4]  = '{8'hFD, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[6]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[7]  = '{8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{8'hEF, 8'h10, 8'h10, 8'h00, 8'h00};
        tbl[9]  = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[12] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h10};
        tbl[13] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[14] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h10};
        tbl[15] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[16] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h10};
        tbl[17] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[18] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h10};
        tbl[19] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[20] = '{8'hEF, 8'h10, 8'h00, 8'h00, 8'h10};
        tbl[21] = '{8'hFF, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[22] = '{8'hFF, 8'h00, 8'h00, 8'h10, 8'h00};
        tbl[23] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[24] = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[25] = '{8'h7F, 8'h80, 8'h80, 8'h00, 8'h00};
        tbl[26] = '{8'hBF, 8'h80, 8'h00, 8'h00, 8'h00};
        tbl[27] = '{8'hBF, 8'h40, 8'h40, 8'h80, 8'h00};
        tbl[28] = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00};
        tbl[29] = '{8'hFF, 8'h00, 8'h00, 8'h40, 8'h00};

        // Reset state with all buttons released on the wire
        reset        = 1'b1;
        sample_valid = 1'b0;
        btn_raw      = 8'hFF;
        repeat (2) @(negedge clk);
        model_reset();
        check_model("reset");
        reset = 1'b0;
        @(negedge clk);

        // Vector table: press/release, glitch, repeat train, release-over-repeat,
        // simultaneous press and release on different bits
        for (int i = 0; i < 30; i++) begin
            poll(tbl[i].raw);
            chk8($sformatf("tbl%0d.btn_state", i), btn_state, tbl[i].st);
            chk8($sformatf("tbl%0d.pressed", i), pressed, tbl[i].p);
            chk8($sformatf("tbl%0d.released", i), released, tbl[i].r);
            chk8($sformatf("tbl%0d.repeat", i), repeat_pulse, tbl[i].rp);
            chk8($sformatf("tbl%0d.any_event", i), {7'b0, any_event},
                 {7'b0, |(tbl[i].p | tbl[i].r | tbl[i].rp)});
            $display("vec %0d raw=%h state=%h p=%h r=%h rp=%h", i, tbl[i].raw,
                     btn_state, pressed, released, repeat_pulse);
        end
        gap(2, "tbl_gap");

        // A (unmasked) held 40 polls: one press, never a repeat
        cnt_p0  = 0;
        cnt_rp0 = 0;
        for (int i = 0; i < 42; i++) begin
            poll(8'hFE);
            check_model("holdA");
            if (pressed[0])      cnt_p0++;
            if (repeat_pulse[0]) cnt_rp0++;
        end
        chk8("holdA.press_count", 8'(cnt_p0), 8'd1);
        chk8("holdA.repeat_count", 8'(cnt_rp0), 8'd0);
        $display("holdA presses=%0d repeats=%0d", cnt_p0, cnt_rp0);
        poll(8'hFF); check_model("relA");
        poll(8'hFF); check_model("relA");

        // DOWN held into REPEAT, then asynchronous reset mid-cycle
        for (int i = 0; i < 10; i++) begin
            poll(8'hDF);
            check_model("holdDown");
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async_reset");
        $display("async reset state=%h", btn_state);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        poll(8'hDF);
        check_model("down_after_reset");
        gap(3, "down_gap");
        poll(8'hDF);
        check_model("down_repress");
        chk8("down_repress.pressed5", {7'b0, pressed[5]}, 8'h01);
        $display("re-press pressed=%h", pressed);

        // Random walk against the reference model, with sample_valid gaps
        do_reset();
        raw = 8'hFF;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                gap($urandom_range(1, 3), "rnd_gap");
            end else begin
                if ($urandom_range(0, 2) == 0)
                    raw = raw ^ (8'h01 << $urandom_range(0, 7));
                poll(raw);
                check_model($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
